evb_horner_multi: RTL
=====================

Name: evb_horner_multi

Overview:
- Parametrised successor to the evaluate-block FSM: evaluates polynomial A at b consecutive x values read from the data buffer.
- Uses Horner's method over the coefficient store S and degree store N.
- Emits one result and status word per point over a ready/valid handshake, then asserts done_evb.
- Sits between the instruction decoder (start_evb, A, b, base address) and the shared S/N/data memories.

Parameters:
word_size, 16, width of x values and coefficients
result_size, 32, width of result/accumulator
num_poly, 8, number of polynomial slots (A range)
max_degree, 10, highest legal degree; S holds num_poly*(max_degree+1) words
buffer_size, 1024, data buffer depth; address width log2(buffer_size)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous active-low reset
rst_instr  in  1  synchronous active-low abort; returns FSM to IDLE
start_evb  in  1  pulse; sampled in IDLE only
A  in  log2(num_poly)  polynomial index
b  in  5  number of points (0..31)
rd_addr_data  in  log2(buffer_size)  base address of first x
en_rd_N / rd_addr_N / N_in  out/out/in  1/log2(num_poly)/5  degree read; N_in=31 means undefined
en_rd_S / rd_addr_S / c_i  out/out/in  1/log2(num_poly*(max_degree+1))/word_size  coefficient read
en_rd_data / rd_addr_x / x_in  out/out/in  1/log2(buffer_size)/word_size  x read
result  out  result_size  evaluation result
status  out  32  per-point status
result_valid  out  1  result/status valid
result_ready  in  1  consumer accepts when high with result_valid
rd_addr_data_updated  out  log2(buffer_size)  rd_addr_data+b mod buffer_size
done_evb  out  1  one-cycle pulse after last point accepted

Behaviour:
- Reset (rst=0): state IDLE; every output 0, including en_rd_*, result_valid, done_evb, result, status, addresses.
- Memory reads: en_rd_* and address are driven in cycle t; data is valid and captured in cycle t+1.
- States:
  - IDLE: on start_evb, latch A, b, base; go to RD_N.
  - RD_N: issue read of N[A].
  - CHECK_N: error if N_in==31 or N_in>max_degree. If b==0, go to DONE.
  - RD_X: issue x read at (base+i) mod buffer_size.
  - LOAD: capture x; issue read of c_N at A*(max_degree+1)+N.
  - MAC: first cycle acc=c_N. Each later cycle acc=acc*x+c_k for k=N-1..0, issuing the next coefficient read in the same cycle. N+1 MAC cycles total.
  - OUT: assert result_valid; hold result/status stable until result_ready; then i++. If i<b go to RD_X, else DONE.
  - DONE: pulse done_evb for one cycle; return to IDLE.
- Latency per valid point: 2+(N+1) cycles to result_valid.
- Arithmetic:
  - Unsigned.
  - acc*x is formed at result_size+word_size bits; truncated to result_size.
  - Overflow flag is sticky per point: set if any discarded product bit or the sum carry-out is 1.
- Error path: no x or S reads. Each of the b points goes directly to OUT with result=0 and status error bit set; b outputs are still produced.
- status word:
  - bit0: ok
  - bit1: undefined polynomial
  - bit2: overflow
  - bits[12:8]: point index i
  - all other bits: 0
- rd_addr_data_updated is set in CHECK_N and holds until the next start_evb.
- Address wrap: x addresses wrap modulo buffer_size.
- start_evb outside IDLE is ignored.
- rst_instr=0 in any state: next cycle IDLE, all enables/valid deasserted, no done_evb pulse.
- result_ready high while result_valid is low has no effect.

Optional Feature:
- Macro EVB_SATURATE_EN.
- Defined: on overflow, result is forced to all ones (2^result_size-1); bit2 is still set.
- Undefined: result is the truncated modulo-2^result_size value; bit2 is set.

Test Plan:
- S slot0={c0=3,c1=4,c2=2,c3=1}, N[0]=3, data={1,2,3}, A=0, b=3, result_ready=1 -> results 10, 27, 60 with status 0x001/0x101/0x201; done_evb pulses once; rd_addr_data_updated=3.
- A=5, N[5]=31, b=3 -> three outputs with result=0 and status 0x002/0x102/0x202; en_rd_S and en_rd_data never asserted; done_evb pulses.
- Backpressure: as the first case but result_ready low for 5 cycles at each point -> result/status held stable; no points lost or duplicated.
- Overflow: N=3, all coeffs 0xFFFF, x=0xFFFF -> bit2 set; without macro, result is the low 32 bits; with EVB_SATURATE_EN, result=0xFFFFFFFF.
- Wrap: base=1022, b=3 -> x reads at 1022, 1023, 0; rd_addr_data_updated=1.
- Abort/reset: rst_instr=0 during MAC of point 1 -> IDLE next cycle, no done_evb. A new start then runs cleanly. Async rst=0 mid-OUT -> all outputs 0 immediately.

Source files
------------

// File: rtl/evb_horner_multi_if.sv
// evb_horner_multi_if: command, S/N/data memory-read and result handshake bundle of evb_horner_multi.
// The master side is the evaluator; the slave side is the decoder/memory/consumer environment.
interface evb_horner_multi_if #(
   parameter int word_size   = 16,
   parameter int result_size = 32,
   parameter int num_poly    = 8,
   parameter int max_degree  = 10,
   parameter int buffer_size = 1024
);
   localparam int PW = (num_poly > 1) ? $clog2(num_poly) : 1;
   localparam int SW = $clog2(num_poly * (max_degree + 1));
   localparam int AW = $clog2(buffer_size);

   logic                   start_evb;
   logic [PW-1:0]          A;
   logic [4:0]             b;
   logic [AW-1:0]          rd_addr_data;
   logic                   en_rd_N;
   logic [PW-1:0]          rd_addr_N;
   logic [4:0]             N_in;
   logic                   en_rd_S;
   logic [SW-1:0]          rd_addr_S;
   logic [word_size-1:0]   c_i;
   logic                   en_rd_data;
   logic [AW-1:0]          rd_addr_x;
   logic [word_size-1:0]   x_in;
   logic [result_size-1:0] result;
   logic [31:0]            status;
   logic                   result_valid;
   logic                   result_ready;
   logic [AW-1:0]          rd_addr_data_updated;
   logic                   done_evb;

   modport master (
      input  start_evb, A, b, rd_addr_data, N_in, c_i, x_in, result_ready,
      output en_rd_N, rd_addr_N, en_rd_S, rd_addr_S, en_rd_data, rd_addr_x,
             result, status, result_valid, rd_addr_data_updated, done_evb
   );

   modport slave (
      output start_evb, A, b, rd_addr_data, N_in, c_i, x_in, result_ready,
      input  en_rd_N, rd_addr_N, en_rd_S, rd_addr_S, en_rd_data, rd_addr_x,
             result, status, result_valid, rd_addr_data_updated, done_evb
   );
endinterface

// File: rtl/evb_horner_multi.sv
// evb_horner_multi: evaluates polynomial slot A at b consecutive buffer x values by Horner's method.
// Build macro EVB_SATURATE_EN clamps overflowed results to all ones (default: truncated result).
module evb_horner_multi #(
   parameter int word_size   = 16,
   parameter int result_size = 32,
   parameter int num_poly    = 8,
   parameter int max_degree  = 10,
   parameter int buffer_size = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rst_instr,
   evb_horner_multi_if.master bus
);
   localparam int PW  = (num_poly > 1) ? $clog2(num_poly) : 1;
   localparam int SW  = $clog2(num_poly * (max_degree + 1));
   localparam int AW  = $clog2(buffer_size);
   localparam int PRW = result_size + word_size;

`ifdef EVB_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_RD_N, S_CHECK_N, S_RD_X, S_LOAD, S_MAC, S_OUT, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [4:0]             i_q, i_d;
   logic [4:0]             b_q, b_d;
   logic [4:0]             n_q, n_d;
   logic [4:0]             k_q, k_d;
   logic                   err_q, err_d;
   logic                   first_q, first_d;
   logic                   ovf_q, ovf_d;
   logic [result_size-1:0] res_q, res_d;
   logic [31:0]            st_q, st_d;
   logic [AW-1:0]          upd_q, upd_d;
   logic [PW-1:0]          a_q, a_d;
   logic [AW-1:0]          base_q, base_d;
   logic [word_size-1:0]   x_q, x_d;
   logic [result_size-1:0] acc_q, acc_d;

   logic [PRW-1:0]         prod;
   logic [result_size:0]   sum;
   logic                   step_ovf;
   logic [result_size-1:0] acc_nxt;
   logic                   ovf_nxt;

   function automatic logic [SW-1:0] coef_addr(input logic [PW-1:0] a, input logic [4:0] k);
      return SW'(32'(a) * 32'(max_degree + 1) + 32'(k));
   endfunction

   function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] base, input logic [4:0] off);
      return AW'((32'(base) + 32'(off)) % 32'(buffer_size));
   endfunction

   function automatic logic [31:0] make_status(input logic [4:0] idx, input logic undef,
                                               input logic ovf);
      return {19'd0, idx, 5'd0, ovf, undef, ~(undef | ovf)};
   endfunction

   function automatic logic [result_size-1:0] final_result(input logic [result_size-1:0] v,
                                                           input logic ovf);
      return (ovf && SAT_EN) ? {result_size{1'b1}} : v;
   endfunction

   // Horner step: any product bit above result_size or a carry out of the add marks overflow
   assign prod     = PRW'(acc_q) * PRW'(x_q);
   assign sum      = {1'b0, prod[result_size-1:0]}
                   + {{(result_size + 1 - word_size){1'b0}}, bus.c_i};
   assign step_ovf = (|prod[PRW-1:result_size]) | sum[result_size];
   assign acc_nxt  = first_q ? result_size'(bus.c_i) : sum[result_size-1:0];
   assign ovf_nxt  = first_q ? 1'b0 : (ovf_q | step_ovf);

   assign bus.result               = res_q;
   assign bus.status               = st_q;
   assign bus.rd_addr_data_updated = upd_q;

   always_comb begin
      state_d          = state_q;
      i_d              = i_q;
      b_d              = b_q;
      n_d              = n_q;
      k_d              = k_q;
      err_d            = err_q;
      first_d          = first_q;
      ovf_d            = ovf_q;
      res_d            = res_q;
      st_d             = st_q;
      upd_d            = upd_q;
      a_d              = a_q;
      base_d           = base_q;
      x_d              = x_q;
      acc_d            = acc_q;
      bus.en_rd_N      = 1'b0;
      bus.rd_addr_N    = '0;
      bus.en_rd_S      = 1'b0;
      bus.rd_addr_S    = '0;
      bus.en_rd_data   = 1'b0;
      bus.rd_addr_x    = '0;
      bus.result_valid = 1'b0;
      bus.done_evb     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start_evb) begin
               a_d     = bus.A;
               b_d     = bus.b;
               base_d  = bus.rd_addr_data;
               state_d = S_RD_N;
            end
         end
         S_RD_N: begin
            bus.en_rd_N   = 1'b1;
            bus.rd_addr_N = a_q;
            state_d       = S_CHECK_N;
         end
         S_CHECK_N: begin
            err_d = (bus.N_in == 5'd31) || (32'(bus.N_in) > 32'(max_degree));
            n_d   = bus.N_in;
            i_d   = 5'd0;
            upd_d = wrap_addr(base_q, b_q);
            if (b_q == 5'd0) begin
               state_d = S_DONE;
            end else if (err_d) begin
               res_d   = '0;
               st_d    = make_status(5'd0, 1'b1, 1'b0);
               state_d = S_OUT;
            end else begin
               state_d = S_RD_X;
            end
         end
         S_RD_X: begin
            bus.en_rd_data = 1'b1;
            bus.rd_addr_x  = wrap_addr(base_q, i_q);
            state_d        = S_LOAD;
         end
         S_LOAD: begin
            x_d           = bus.x_in;
            bus.en_rd_S   = 1'b1;
            bus.rd_addr_S = coef_addr(a_q, n_q);
            k_d           = n_q;
            first_d       = 1'b1;
            ovf_d         = 1'b0;
            state_d       = S_MAC;
         end
         S_MAC: begin
            // k_q names the coefficient arriving this cycle; the read for k_q-1 overlaps it
            acc_d   = acc_nxt;
            ovf_d   = ovf_nxt;
            first_d = 1'b0;
            if (k_q != 5'd0) begin
               bus.en_rd_S   = 1'b1;
               bus.rd_addr_S = coef_addr(a_q, k_q - 5'd1);
               k_d           = k_q - 5'd1;
            end else begin
               res_d   = final_result(acc_nxt, ovf_nxt);
               st_d    = make_status(i_q, 1'b0, ovf_nxt);
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            bus.result_valid = 1'b1;
            if (bus.result_ready) begin
               i_d = i_q + 5'd1;
               if (({1'b0, i_q} + 6'd1) < {1'b0, b_q}) begin
                  if (err_q) begin
                     res_d   = '0;
                     st_d    = make_status(i_d, 1'b1, 1'b0);
                     state_d = S_OUT;
                  end else begin
                     state_d = S_RD_X;
                  end
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            bus.done_evb = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (!rst_instr) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         b_q     <= '0;
         n_q     <= '0;
         k_q     <= '0;
         err_q   <= 1'b0;
         first_q <= 1'b0;
         ovf_q   <= 1'b0;
         res_q   <= '0;
         st_q    <= '0;
         upd_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         b_q     <= b_d;
         n_q     <= n_d;
         k_q     <= k_d;
         err_q   <= err_d;
         first_q <= first_d;
         ovf_q   <= ovf_d;
         res_q   <= res_d;
         st_q    <= st_d;
         upd_q   <= upd_d;
      end
   end

   always_ff @(posedge clk) begin
      a_q    <= a_d;
      base_q <= base_d;
      x_q    <= x_d;
      acc_q  <= acc_d;
   end
endmodule
